// File: rtl/wb_ddr2_port_arbiter_pkg.sv
// Shared Wishbone arbiter types: cycle-type codes, FSM state encoding and bus widths.
// Pure definitions, no logic.
package wb_arb_pkg;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_INCR    = 3'b010,
    CTI_EOB     = 3'b111
  } cti_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/wb_ddr2_port_arbiter_rr_pick.sv
// Round-robin priority encoder: first requester at or after (last+1) mod N, zero latency.
// No backpressure; gnt is all-zero when nothing requests.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW-1:0] pos;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 1; k <= N; k++) begin
      pos = IW'((int'(last) + k) % N);
      if (!found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/wb_ddr2_port_arbiter.sv
// Round-robin Wishbone arbiter sharing one DDR2 port; 1-cycle grant, combinational ack/data path.
// Ownership is held for the whole cyc; a stalled strobe is terminated with a one-cycle err.
module wb_ddr2_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int TIMEOUT     = 1023
) (
  input  logic                      wb_clk,
  input  logic                      wb_rst,
  input  logic [NUM_MASTERS*AW-1:0] m_adr_i,
  input  logic [NUM_MASTERS*2-1:0]  m_bte_i,
  input  logic [NUM_MASTERS*3-1:0]  m_cti_i,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS*SW-1:0] m_sel_i,
  input  logic [NUM_MASTERS*DW-1:0] m_dat_i,
  output logic [DW-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic [NUM_MASTERS-1:0]    m_rty_o,
  output logic [AW-1:0]             s_adr_o,
  output logic [1:0]                s_bte_o,
  output logic [2:0]                s_cti_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_we_o,
  output logic [SW-1:0]             s_sel_o,
  output logic [DW-1:0]             s_dat_o,
  input  logic [DW-1:0]             s_dat_i,
  input  logic                      s_ack_i,
  output logic [NUM_MASTERS-1:0]    grant_o,
  output logic                      busy_o
);

  localparam int         N       = NUM_MASTERS;
  localparam int         IW      = $clog2(N);
  localparam logic [9:0] WD_LAST = 10'(TIMEOUT - 1);

  logic [AW-1:0] adr_a [N];
  logic [1:0]    bte_a [N];
  logic [2:0]    cti_a [N];
  logic [SW-1:0] sel_a [N];
  logic [DW-1:0] dat_a [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign adr_a[i] = m_adr_i[i*AW +: AW];
    assign bte_a[i] = m_bte_i[i*2 +: 2];
    assign cti_a[i] = m_cti_i[i*3 +: 3];
    assign sel_a[i] = m_sel_i[i*SW +: SW];
    assign dat_a[i] = m_dat_i[i*DW +: DW];
  end

  arb_state_t    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] last_q, last_d;
  logic [9:0]    wd_cnt_q, wd_cnt_d;
  logic          err_q, err_d;

  logic [N-1:0]  pick_gnt;
  logic [IW-1:0] pick_idx;
  logic          busy;
  logic          stall;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req  (m_cyc_i),
    .last (last_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  assign busy = (state_q == ST_BUSY);

  // While BUSY, last_q always holds the current owner's index.
  always_comb begin
    s_adr_o = '0;
    s_bte_o = '0;
    s_cti_o = CTI_CLASSIC;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_dat_o = '0;
    if (busy) begin
      s_adr_o = adr_a[last_q];
      s_bte_o = bte_a[last_q];
      s_cti_o = cti_a[last_q];
      s_cyc_o = m_cyc_i[last_q];
      s_stb_o = m_stb_i[last_q] & ~err_q;
      s_we_o  = m_we_i[last_q];
      s_sel_o = sel_a[last_q];
      s_dat_o = dat_a[last_q];
    end
  end

  assign stall = s_stb_o & ~s_ack_i;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    wd_cnt_d = '0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|m_cyc_i) begin
          state_d = ST_BUSY;
          grant_d = pick_gnt;
          last_d  = pick_idx;
        end
      end
      ST_BUSY: begin
        if (!m_cyc_i[last_q]) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end else if (stall) begin
          // Counter lands on TIMEOUT together with the err pulse; the gated strobe then clears it.
          wd_cnt_d = wd_cnt_q + 10'd1;
          err_d    = (wd_cnt_q == WD_LAST);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      last_q   <= IW'(N - 1);
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
    end
  end

  assign m_ack_o = grant_q & {N{s_ack_i}};
  assign m_err_o = grant_q & {N{err_q}};
  assign m_rty_o = '0;
  assign m_dat_o = busy ? s_dat_i : '0;
  assign grant_o = grant_q;
  assign busy_o  = busy;

endmodule

// File: tb/tb_wb_ddr2_port_arbiter.sv
// Bench for wb_ddr2_port_arbiter: directed vector table, scripted corner sequences and a
// randomized run, all checked against a transaction-level ownership/watchdog model.
module tb_wb_ddr2_port_arbiter;

  localparam int NM = 4;
  localparam int TO = 15;

  logic             wb_clk = 1'b0;
  logic             wb_rst;
  logic [NM*32-1:0] m_adr_i, m_dat_i;
  logic [NM*2-1:0]  m_bte_i;
  logic [NM*3-1:0]  m_cti_i;
  logic [NM-1:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [NM*4-1:0]  m_sel_i;
  logic [31:0]      m_dat_o;
  logic [NM-1:0]    m_ack_o, m_err_o, m_rty_o;
  logic [31:0]      s_adr_o, s_dat_o, s_dat_i;
  logic [1:0]       s_bte_o;
  logic [2:0]       s_cti_o;
  logic             s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic [3:0]       s_sel_o;
  logic [NM-1:0]    grant_o;
  logic             busy_o;

  wb_ddr2_port_arbiter #(.NUM_MASTERS(NM), .TIMEOUT(TO)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .m_adr_i(m_adr_i), .m_bte_i(m_bte_i), .m_cti_i(m_cti_i), .m_cyc_i(m_cyc_i),
    .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i), .m_dat_i(m_dat_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_bte_o(s_bte_o), .s_cti_o(s_cti_o), .s_cyc_o(s_cyc_o),
    .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .grant_o(grant_o), .busy_o(busy_o)
  );

  always #5 wb_clk = ~wb_clk;

  int checks = 0;
  int errors = 0;

  // Master agents: total beats left, beats per bus cycle, beats done this cycle, one-cycle cyc gap.
  int tot [NM];
  int blen [NM];
  int done [NM];
  bit gap [NM];
  bit rand_mode;
  int slave_lat, wcnt;

  // Reference model: current owner (-1 idle), last granted, stall run length, err expected now.
  int own, mlast, run;
  bit merr;
  int glog [$];
  int err_seen [NM];
  int stall1, busy_cycles;

  typedef struct {
    logic [3:0] cyc;
    logic       ack;
    logic [3:0] grant;
    logic       busy;
    logic [3:0] mack;
    logic       scyc;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [NM-1:0] r, input int l);
    for (int k = 1; k <= NM; k++)
      if (r[(l + k) % NM +: 1]) return (l + k) % NM;
    return -1;
  endfunction

  function automatic int glog_at(input int k);
    return (glog.size() > k) ? glog[k] : -1;
  endfunction

  function automatic logic [75:0] sbus();
    return {s_adr_o, s_bte_o, s_cti_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_dat_o};
  endfunction

  task automatic drive_masters();
    for (int i = 0; i < NM; i++) begin
      m_cyc_i[i +: 1] = (tot[i] > 0) && !gap[i];
      m_stb_i[i +: 1] = m_cyc_i[i +: 1] && (!rand_mode || ($urandom_range(0, 3) != 0));
      m_we_i[i +: 1]  = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
      m_adr_i[i*32 +: 32] = rand_mode ? $urandom : (32'h100 << i);
      m_dat_i[i*32 +: 32] = $urandom;
      m_sel_i[i*4 +: 4]   = rand_mode ? 4'($urandom) : 4'hf;
      m_cti_i[i*3 +: 3]   = (blen[i] == 1) ? 3'b000 : ((tot[i] == 1) ? 3'b111 : 3'b010);
      m_bte_i[i*2 +: 2]   = 2'($urandom);
    end
  endtask

  task automatic run_cycle();
    logic [NM-1:0] one, eg, ea, ee;
    logic [75:0]   esb;
    bit            busy_m, stall;
    int            g;
    one = 1;
    @(posedge wb_clk); #1;
    drive_masters();
    #1;
    s_dat_i = $urandom;
    if (s_stb_o) begin
      s_ack_i = (wcnt >= slave_lat);
      wcnt = s_ack_i ? 0 : wcnt + 1;
      if (s_ack_i && rand_mode)
        slave_lat = ($urandom_range(0, 7) == 0) ? 40 : int'($urandom_range(0, 3));
    end else begin
      s_ack_i = 1'b0;
      wcnt = 0;
    end
    #1;
    busy_m = (own >= 0);
    g  = busy_m ? own : 0;
    eg = busy_m ? (one << g) : '0;
    esb = busy_m ? {m_adr_i[g*32 +: 32], m_bte_i[g*2 +: 2], m_cti_i[g*3 +: 3], m_cyc_i[g +: 1],
                    m_stb_i[g +: 1] & ~merr, m_we_i[g +: 1], m_sel_i[g*4 +: 4], m_dat_i[g*32 +: 32]}
                 : '0;
    ea = (busy_m && s_ack_i) ? eg : '0;
    ee = (busy_m && merr) ? eg : '0;
    chk("grant", grant_o, eg);
    chk("busy", busy_o, busy_m);
    chk("sbus", sbus(), esb);
    chk("ack", m_ack_o, ea);
    chk("err", m_err_o, ee);
    chk("rty", m_rty_o, '0);
    if (busy_m) chk("rdata", m_dat_o, s_dat_i);

    for (int i = 0; i < NM; i++) err_seen[i] += int'(m_err_o[i +: 1]);
    if (s_stb_o && grant_o == 4'b0010) stall1++;
    if (busy_o) busy_cycles++;

    if (!busy_m) begin
      if (|m_cyc_i) begin
        own = pick(m_cyc_i, mlast);
        mlast = own;
        glog.push_back(own);
      end
      run = 0;
      merr = 1'b0;
    end else if (!m_cyc_i[g +: 1]) begin
      own = -1;
      run = 0;
      merr = 1'b0;
    end else begin
      stall = m_stb_i[g +: 1] && !merr && !s_ack_i;
      run = stall ? run + 1 : 0;
      merr = stall && (run == TO);
    end

    for (int i = 0; i < NM; i++) begin
      if (gap[i]) begin
        gap[i] = 1'b0;
      end else begin
        if (m_ack_o[i +: 1] && tot[i] > 0) begin
          tot[i]--;
          done[i]++;
          if (done[i] >= blen[i] || tot[i] == 0) begin
            gap[i] = 1'b1;
            done[i] = 0;
          end
        end
        if (m_err_o[i +: 1]) begin
          tot[i] = 0;
          done[i] = 0;
          gap[i] = 1'b1;
        end
      end
      if (rand_mode && tot[i] == 0 && !gap[i] && $urandom_range(0, 5) == 0) begin
        blen[i] = $urandom_range(1, 4);
        tot[i] = blen[i];
      end
    end
  endtask

  task automatic do_reset();
    wb_rst = 1'b1;
    m_adr_i = '0; m_dat_i = '0; m_bte_i = '0; m_cti_i = '0;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_sel_i = '0;
    s_ack_i = 1'b0; s_dat_i = '0;
    for (int i = 0; i < NM; i++) begin
      tot[i] = 0; blen[i] = 1; done[i] = 0; gap[i] = 1'b0; err_seen[i] = 0;
    end
    own = -1; mlast = NM - 1; run = 0; merr = 1'b0; wcnt = 0;
    stall1 = 0; busy_cycles = 0;
    glog.delete();
    repeat (2) @(posedge wb_clk);
    #1;
    chk("rst_out", {grant_o, busy_o, m_ack_o, m_err_o, m_rty_o, m_dat_o, sbus()}, '0);
    @(negedge wb_clk);
    wb_rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{4'b1010, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[1] = '{4'b1010, 1'b0, 4'b0010, 1'b1, 4'b0000, 1'b1};
    tbl[2] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 4'b0010, 1'b1};
    tbl[3] = '{4'b1000, 1'b0, 4'b0010, 1'b1, 4'b0000, 1'b0};
    tbl[4] = '{4'b1000, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[5] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 4'b1000, 1'b1};
    tbl[6] = '{4'b0000, 1'b0, 4'b1000, 1'b1, 4'b0000, 1'b0};
    tbl[7] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0};
    rand_mode = 1'b0;
    slave_lat = 3;

    // Masters 1 and 3 request together straight after reset.
    do_reset();
    for (int r = 0; r < 8; r++) begin
      @(posedge wb_clk); #1;
      m_cyc_i = tbl[r].cyc;
      m_stb_i = tbl[r].cyc;
      s_ack_i = tbl[r].ack;
      #2;
      chk($sformatf("tbl%0d_grant", r), grant_o, tbl[r].grant);
      chk($sformatf("tbl%0d_busy", r), busy_o, tbl[r].busy);
      chk($sformatf("tbl%0d_ack", r), m_ack_o, tbl[r].mack);
      chk($sformatf("tbl%0d_scyc", r), s_cyc_o, tbl[r].scyc);
    end

    // Classic read by master 0, slave acks 3 cycles after stb.
    do_reset();
    slave_lat = 3;
    tot[0] = 1;
    repeat (10) run_cycle();
    chk("t2_owner", glog_at(0), 0);
    chk("t2_busy_len", busy_cycles, 5);
    chk("t2_done", tot[0], 0);

    // All masters busy, one beat per bus cycle: strict rotation.
    do_reset();
    slave_lat = 0;
    for (int i = 0; i < NM; i++) tot[i] = 2;
    repeat (40) run_cycle();
    for (int k = 0; k < 5; k++) chk($sformatf("t3_rot%0d", k), glog_at(k), k % NM);
    begin
      int rep = 0;
      for (int k = 1; k < glog.size(); k++) if (glog[k] == glog[k-1]) rep++;
      chk("t3_norepeat", rep, 0);
    end

    // 8-beat burst on master 2 is not preempted by master 0.
    do_reset();
    slave_lat = 1;
    tot[2] = 8; blen[2] = 8;
    repeat (3) run_cycle();
    tot[0] = 1;
    repeat (40) run_cycle();
    chk("t4_first", glog_at(0), 2);
    chk("t4_second", glog_at(1), 0);
    chk("t4_count", glog.size(), 2);
    chk("t4_beats", tot[2], 0);

    // Slave never acks: watchdog errors each owner in turn.
    do_reset();
    slave_lat = 1000;
    tot[1] = 1; tot[3] = 1;
    repeat (45) run_cycle();
    chk("t5_err1", err_seen[1], 1);
    chk("t5_stall1", stall1, TO);
    chk("t5_order", glog_at(1), 3);
    chk("t5_err3", err_seen[3], 1);

    // Asynchronous reset in the middle of a burst.
    do_reset();
    slave_lat = 1;
    tot[2] = 8; blen[2] = 8;
    repeat (4) run_cycle();
    chk("t6_pre_busy", busy_o, 1'b1);
    #2;
    wb_rst = 1'b1;
    #1;
    chk("t6_async", {grant_o, busy_o, m_ack_o, m_err_o, m_dat_o, sbus()}, '0);
    do_reset();
    slave_lat = 1;
    tot[0] = 1; tot[1] = 1; tot[3] = 1;
    repeat (5) run_cycle();
    chk("t6_first", glog_at(0), 0);

    // Randomized traffic against the model.
    do_reset();
    rand_mode = 1'b1;
    slave_lat = 2;
    repeat (3000) run_cycle();
    rand_mode = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
